wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_arbiter_pkg.sv | 13 +
 rtl/wrr_arbiter_rr_pick.sv | 31 +++
 rtl/wrr_arbiter.sv | 142 ++++++++++++++
 tb/tb_wrr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and default sizing for the weighted round-robin arbiter.
// Holds the arbiter state enum and default parameter constants.
package wrr_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WEIGHT_W = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
// Ports: i_req requests, i_ptr last owner; o_gnt one-hot winner,
//        o_idx winner index, o_any high when any request is present.
module rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDW-1:0]     o_idx,
    output logic               o_any
);

    // Search starts just after the pointer and reaches the pointer last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_any = 1'b1;
                o_gnt[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
                o_idx = IDW'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester burst lengths.
// Ports: clk, reset (sync, active-high), req, weight (packed slices);
//        gnt/gnt_id/gnt_valid registered, burst_last combinational.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          gnt_valid,
    output logic                          burst_last
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [IDW-1:0]       r_gnt_id;
    logic                 r_gnt_valid;
    logic [IDW-1:0]       r_ptr;
    logic [WEIGHT_W-1:0]  r_cnt;
    logic [WEIGHT_W-1:0]  r_eff;

    state_t               w_state_n;
    logic [NUM_REQ-1:0]   w_gnt_n;
    logic [IDW-1:0]       w_gnt_id_n;
    logic                 w_gnt_valid_n;
    logic [IDW-1:0]       w_ptr_n;
    logic [WEIGHT_W-1:0]  w_cnt_n;
    logic [WEIGHT_W-1:0]  w_eff_n;

    logic                 w_beat;
    logic [WEIGHT_W:0]    w_cnt_inc;
    logic                 w_last;
    logic                 w_release;
    logic [IDW-1:0]       w_pick_ptr;
    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [IDW-1:0]       w_pick_idx;
    logic                 w_pick_any;
    logic [WEIGHT_W-1:0]  w_win_w;
    logic [WEIGHT_W-1:0]  w_win_eff;

    assign w_beat    = (r_state == S_GRANT) && req[r_gnt_id];
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    assign w_last    = w_beat && (w_cnt_inc == {1'b0, r_eff});
    assign w_release = (r_state == S_GRANT) && (!req[r_gnt_id] || w_last);

    // While owning, the current owner becomes the new pointer on release.
    assign w_pick_ptr = (r_state == S_GRANT) ? r_gnt_id : r_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_req (req),
        .i_ptr (w_pick_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // A zero weight still allows a single beat.
    assign w_win_w   = weight[int'(w_pick_idx)*WEIGHT_W +: WEIGHT_W];
    assign w_win_eff = (w_win_w == '0) ? WEIGHT_W'(1) : w_win_w;

    always_comb begin
        w_state_n     = r_state;
        w_gnt_n       = r_gnt;
        w_gnt_id_n    = r_gnt_id;
        w_gnt_valid_n = r_gnt_valid;
        w_ptr_n       = r_ptr;
        w_cnt_n       = r_cnt;
        w_eff_n       = r_eff;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_any) begin
                    w_state_n     = S_GRANT;
                    w_gnt_n       = w_pick_gnt;
                    w_gnt_id_n    = w_pick_idx;
                    w_gnt_valid_n = 1'b1;
                    w_cnt_n       = '0;
                    w_eff_n       = w_win_eff;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_n = r_gnt_id;
                    if (w_pick_any) begin
                        w_gnt_n       = w_pick_gnt;
                        w_gnt_id_n    = w_pick_idx;
                        w_gnt_valid_n = 1'b1;
                        w_cnt_n       = '0;
                        w_eff_n       = w_win_eff;
                    end else begin
                        w_state_n     = S_IDLE;
                        w_gnt_n       = '0;
                        w_gnt_id_n    = '0;
                        w_gnt_valid_n = 1'b0;
                        w_cnt_n       = '0;
                    end
                end else if (w_beat) begin
                    w_cnt_n = w_cnt_inc[WEIGHT_W-1:0];
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= IDW'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_eff       <= WEIGHT_W'(1);
        end else begin
            r_state     <= w_state_n;
            r_gnt       <= w_gnt_n;
            r_gnt_id    <= w_gnt_id_n;
            r_gnt_valid <= w_gnt_valid_n;
            r_ptr       <= w_ptr_n;
            r_cnt       <= w_cnt_n;
            r_eff       <= w_eff_n;
        end
    end

    assign gnt        = r_gnt;
    assign gnt_id     = r_gnt_id;
    assign gnt_valid  = r_gnt_valid;
    assign burst_last = w_last && !reset;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios on a 4-way
// instance and a randomized run on a 5-way instance against a model.
module tb_wrr_arbiter;

    logic        clk;

    logic        rst4;
    logic [3:0]  req4;
    logic [15:0] w4;
    logic [3:0]  gnt4;
    logic [1:0]  id4;
    logic        gv4;
    logic        bl4;

    logic        rst5;
    logic [4:0]  req5;
    logic [19:0] w5;
    logic [4:0]  gnt5;
    logic [2:0]  id5;
    logic        gv5;
    logic        bl5;

    int n_checks = 0;
    int n_fail   = 0;

    wrr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut4 (
        .clk        (clk),
        .reset      (rst4),
        .req        (req4),
        .weight     (w4),
        .gnt        (gnt4),
        .gnt_id     (id4),
        .gnt_valid  (gv4),
        .burst_last (bl4)
    );

    wrr_arbiter #(.NUM_REQ(5), .WEIGHT_W(4)) dut5 (
        .clk        (clk),
        .reset      (rst5),
        .req        (req5),
        .weight     (w5),
        .gnt        (gnt5),
        .gnt_id     (id5),
        .gnt_valid  (gv5),
        .burst_last (bl5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset4();
        rst4 = 1'b1;
        req4 = '0;
        tick();
        tick();
        rst4 = 1'b0;
    endtask

    task automatic test_reset();
        rst4 = 1'b1;
        req4 = 4'b1111;
        w4   = 16'h1111;
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b0000 || id4 !== 2'd0 || gv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got gnt=%b id=%0d gv=%b want 0000 0 0",
                     gnt4, id4, gv4);
        end
        n_checks++;
        if (bl4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bl: got %b want 0", bl4);
        end
        rst4 = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b0001 || gv4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first: got gnt=%b gv=%b want 0001 1",
                     gnt4, gv4);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] exp;
        do_reset4();
        w4   = 16'h1111;
        req4 = 4'b0101;
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL alt_latency: got %b want 0000", gnt4);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 1) ? 4'b0100 : 4'b0001;
            @(negedge clk);
            n_checks++;
            if (gnt4 !== exp || bl4 !== 1'b1) begin
                n_fail++;
                $display("FAIL alt_gnt c%0d: got gnt=%b bl=%b want %b 1",
                         i, gnt4, bl4, exp);
            end
            tick();
        end
    endtask

    task automatic test_weighted();
        logic [3:0] exp_g;
        logic       exp_b;
        int         p;
        do_reset4();
        w4   = {4'd1, 4'd1, 4'd2, 4'd3};
        req4 = 4'b0011;
        tick();
        for (int i = 0; i < 10; i++) begin
            p     = i % 5;
            exp_g = (p < 3) ? 4'b0001 : 4'b0010;
            exp_b = (p == 2) || (p == 4);
            @(negedge clk);
            n_checks++;
            if (gnt4 !== exp_g || bl4 !== exp_b) begin
                n_fail++;
                $display("FAIL wgt c%0d: got gnt=%b bl=%b want %b %b",
                         i, gnt4, bl4, exp_g, exp_b);
            end
            tick();
        end
    endtask

    task automatic test_drop();
        do_reset4();
        w4   = 16'h1511;
        req4 = 4'b1100;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt4 !== 4'b0100 || bl4 !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_own c%0d: got gnt=%b bl=%b want 0100 0",
                         i, gnt4, bl4);
            end
            tick();
        end
        req4 = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b0100 || bl4 !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_rel: got gnt=%b bl=%b want 0100 0",
                     gnt4, bl4);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b1000 || id4 !== 2'd3 || gv4 !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_next: got gnt=%b id=%0d gv=%b want 1000 3 1",
                     gnt4, id4, gv4);
        end
    endtask

    task automatic test_zero_weight();
        do_reset4();
        w4   = 16'h0000;
        req4 = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt4 !== 4'b0010 || bl4 !== 1'b1 || id4 !== 2'd1) begin
                n_fail++;
                $display("FAIL zero_w c%0d: got gnt=%b bl=%b id=%0d want 0010 1 1",
                         i, gnt4, bl4, id4);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset4();
        w4   = 16'h4000;
        req4 = 4'b1000;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt4 !== 4'b1000 || bl4 !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_own c%0d: got gnt=%b bl=%b want 1000 0",
                         i, gnt4, bl4);
            end
            tick();
        end
        rst4 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bl4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_bl: got %b want 0", bl4);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b0000 || gv4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_clr: got gnt=%b gv=%b want 0000 0", gnt4, gv4);
        end
        rst4 = 1'b0;
        req4 = 4'b1001;
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt4 !== 4'b0001 || id4 !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_first: got gnt=%b id=%0d want 0001 0",
                     gnt4, id4);
        end
    endtask

    // Reference model for the 5-way instance: owner (-1 = none),
    // last-owner pointer, and beats still allowed in the current burst.
    int m_owner;
    int m_ptr;
    int m_left;

    function automatic int rr_next(logic [4:0] r, int p);
        for (int k = 1; k <= 5; k++) begin
            if (r[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    function automatic int eff_of(logic [19:0] w, int j);
        int v;
        v = int'(w[j*4 +: 4]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step();
        int  nxt;
        bit  beat;
        bit  last;
        beat = (m_owner >= 0) && req5[m_owner];
        last = beat && (m_left == 1);
        if (m_owner < 0) begin
            nxt = rr_next(req5, m_ptr);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_left  = eff_of(w5, nxt);
            end
        end else if (!beat || last) begin
            m_ptr = m_owner;
            nxt   = rr_next(req5, m_owner);
            m_owner = nxt;
            if (nxt >= 0) m_left = eff_of(w5, nxt);
        end else begin
            m_left--;
        end
    endtask

    task automatic test_random();
        logic [4:0] exp_g;
        logic [2:0] exp_id;
        logic       exp_b;
        int         waits[5];
        int         bound;
        bound = 4 * 15 + 2;
        rst5 = 1'b1;
        req5 = '0;
        w5   = '0;
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt5 !== 5'b0 || gv5 !== 1'b0 || id5 !== 3'd0) begin
            n_fail++;
            $display("FAIL rnd_reset: got gnt=%b gv=%b id=%0d want 0 0 0",
                     gnt5, gv5, id5);
        end
        tick();
        rst5    = 1'b0;
        m_owner = -1;
        m_ptr   = 4;
        m_left  = 1;
        foreach (waits[i]) waits[i] = 0;
        req5 = 5'($urandom);
        w5   = 20'($urandom);
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 9) == 0) req5[i] = ~req5[i];
                if ($urandom_range(0, 19) == 0) w5[i*4 +: 4] = 4'($urandom);
            end
            @(negedge clk);
            exp_g  = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
            exp_id = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            exp_b  = (m_owner >= 0) && req5[m_owner] && (m_left == 1);
            n_checks++;
            if (gnt5 !== exp_g || id5 !== exp_id || gv5 !== (m_owner >= 0)) begin
                n_fail++;
                $display("FAIL rnd_gnt c%0d: got gnt=%b id=%0d gv=%b want %b %0d %b",
                         c, gnt5, id5, gv5, exp_g, exp_id, (m_owner >= 0));
            end
            n_checks++;
            if (bl5 !== exp_b) begin
                n_fail++;
                $display("FAIL rnd_bl c%0d: got %b want %b", c, bl5, exp_b);
            end
            n_checks++;
            if (!$onehot0(gnt5) || gv5 !== (|gnt5)) begin
                n_fail++;
                $display("FAIL rnd_onehot c%0d: got gnt=%b gv=%b want onehot0",
                         c, gnt5, gv5);
            end
            for (int i = 0; i < 5; i++) begin
                if (req5[i] && !gnt5[i]) waits[i]++;
                else waits[i] = 0;
                n_checks++;
                if (waits[i] > bound) begin
                    n_fail++;
                    $display("FAIL rnd_starve r%0d c%0d: waited %0d want <= %0d",
                             i, c, waits[i], bound);
                end
            end
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    initial begin
        clk  = 1'b0;
        rst4 = 1'b1;
        req4 = '0;
        w4   = '0;
        rst5 = 1'b1;
        req5 = '0;
        w5   = '0;
        tick();
        tick();
        test_reset();
        test_alternate();
        test_weighted();
        test_drop();
        test_zero_weight();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
